soc_msp430_trace_arbiter: RTL
=============================

Name: soc_msp430_trace_arbiter

Overview:
Captures instruction-decode events from both MSP430 cores of the dual-core SoC into one shared trace FIFO. Each event holds core id, PC, opcode, IRQ flag and timestamp. A round-robin arbiter resolves same-cycle contention between the cores. Events drain through a valid/ready port to the bench trace logger, which replaces per-core polling through a core-select mux.

Parameters:
DEPTH  8   shared FIFO entries; power of two, >=2
TS_W   16  timestamp width, in mclk cycles

Ports:
mclk           input   1               clock
puc_rst        input   1               synchronous reset, active-high
trace_en       input   1               enables event capture
clear_stats    input   1               clears drop counters and overflow flag
c0_decode      input   1               core 0 decode strobe
c0_pc          input   16              core 0 PC
c0_ir          input   16              core 0 opcode
c0_irq_detect  input   1               core 0 IRQ entry flag
c1_decode, c1_pc, c1_ir, c1_irq_detect  input  1/16/16/1  same signals for core 1
trc_valid      output  1               trace entry available
trc_ready      input   1               consumer accepts entry
trc_core       output  1               source core of head entry
trc_pc         output  16              PC of head entry
trc_ir         output  16              opcode of head entry
trc_irq        output  1               IRQ flag of head entry
trc_ts         output  TS_W            timestamp of head entry
fifo_level     output  $clog2(DEPTH)+1 current occupancy
drop_cnt0      output  16              events lost from core 0
drop_cnt1      output  16              events lost from core 1
overflow       output  1               sticky: any event lost

Behaviour:
- All state is synchronous to mclk. puc_rst is sampled on the rising edge and has priority over every other input.
- Reset values:
  - trc_valid=0, fifo_level=0, drop_cnt0/1=0, overflow=0.
  - Timestamp counter=0, both slots empty, last_grant=1, so core 0 wins the first tie.
  - trc_core/pc/ir/irq/ts read 0 while the FIFO is empty after reset.
- Timestamp: free-running TS_W counter. Increments every cycle and wraps from all-ones to 0.
- Capture, per core:
  - One pending slot holds {pc, ir, irq_detect, ts}.
  - When cN_decode=1 and trace_en=1, the slot loads on that edge with the current timestamp value.
  - When trace_en=0, decode strobes are ignored; they load nothing and count no drops. Pending slots and FIFO still drain.
- Drop rule:
  - A decode arrives while the slot is pending and the slot is not granted in the same cycle -> new event discarded, old event kept.
  - On a drop: drop_cntN increments, saturating at 16'hFFFF, and overflow is set.
  - A decode in the same cycle the slot is granted -> the slot reloads with the new event; no drop.
- Arbitration, one grant per cycle:
  - Grant is possible when push_ok = (fifo_level<DEPTH) || (trc_valid && trc_ready).
  - Only one slot pending -> grant it.
  - Both slots pending -> grant the core != last_grant.
  - last_grant updates only on a grant.
  - The granted slot is written to the FIFO tail with its core id, and the slot clears unless it reloads as above.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle -> fifo_level unchanged; legal when full or empty+pending. At empty, the popped entry must already be at head, so no bypass.
  - trc_valid = (fifo_level!=0). Outputs show the head entry combinationally from storage.
  - A pop occurs when trc_valid && trc_ready. trc_ready while empty has no effect.
- Latency: decode at edge N -> slot pending after N -> FIFO write at edge N+1 -> trc_valid=1 after N+1, given no contention.
- Stats:
  - clear_stats=1 zeroes drop_cnt0/1 and overflow.
  - If a drop occurs in the same cycle as clear_stats, clear wins; the counter reads 0.
  - FIFO contents are unaffected.
- puc_rst mid-operation flushes the FIFO, both slots and the stats. Entries in flight are lost without being counted as drops.
- Events from one core leave the FIFO in capture order. Cross-core order follows grant order.

Test Plan:
1. Single event: reset, trace_en=1, c0_decode pulse with pc=16'hF800, ir=16'h4303 at ts=5 -> two edges later trc_valid=1, trc_core=0, trc_pc=F800, trc_ir=4303, trc_ts=5; pop with trc_ready -> trc_valid=0, fifo_level=0.
2. Tie and round-robin: c0 and c1 decode in the same cycle, twice, 4 cycles apart, trc_ready=0 -> FIFO order is core0, core1, core0, core1; fifo_level=4.
3. Overflow and drops: DEPTH=8, trc_ready=0, c0_decode held high for 12 cycles -> fifo_level=8, one event held in the slot, drop_cnt0=3, overflow=1. Then clear_stats -> both counters 0, overflow=0, fifo_level still 8.
4. Full with simultaneous push/pop: FIFO full, slot pending, trc_ready=1 for one cycle -> head popped, pending event written, fifo_level stays 8, drop_cnt0 unchanged.
5. Gating and reset: trace_en=0 with decodes on both cores -> no entries and no drops. Then 3 entries queued, puc_rst pulsed -> fifo_level=0, trc_valid=0, timestamp restarts at 0, next c1 event carries ts equal to its capture cycle.
6. Wrap checks: run 20 entries through DEPTH=8 with random trc_ready -> data intact across pointer wrap. Run past 2^TS_W cycles -> trc_ts wraps to 0.

Source files
------------

// File: rtl/soc_msp430_trace_arbiter.sv
// Merges decode-event traces from both MSP430 cores into one shared FIFO.
// Each core owns a one-entry pending slot; a round-robin arbiter moves one slot per cycle into the FIFO.
module soc_msp430_trace_arbiter #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     mclk,
    input  logic                     puc_rst,
    input  logic                     trace_en,
    input  logic                     clear_stats,
    input  logic                     c0_decode,
    input  logic [15:0]              c0_pc,
    input  logic [15:0]              c0_ir,
    input  logic                     c0_irq_detect,
    input  logic                     c1_decode,
    input  logic [15:0]              c1_pc,
    input  logic [15:0]              c1_ir,
    input  logic                     c1_irq_detect,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic                     trc_core,
    output logic [15:0]              trc_pc,
    output logic [15:0]              trc_ir,
    output logic                     trc_irq,
    output logic [TS_W-1:0]          trc_ts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_cnt0,
    output logic [15:0]              drop_cnt1,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef struct packed {
        logic            core;
        logic [15:0]     pc;
        logic [15:0]     ir;
        logic            irq;
        logic [TS_W-1:0] ts;
    } entry_t;

    logic [TS_W-1:0] ts_cnt_q;
    entry_t          slot_q [2];
    entry_t          slot_d [2];
    logic [1:0]      pend_q, pend_d;
    logic            last_grant_q;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     drop0_q, drop1_q;
    logic            ovf_q;

    logic [1:0]      dec, granted, drop;
    entry_t          new_ev [2];
    logic            pop, push_ok, gnt_valid, gnt_core;

    // Trace port: an entry transfers on any edge where trc_valid and trc_ready are both high;
    // trc_valid depends only on occupancy, and head fields are stable until that transfer.
    assign trc_valid = (level_q != '0);
    assign pop       = trc_valid && trc_ready;
    assign push_ok   = (level_q < DEPTH_L) || pop;
    assign gnt_valid = push_ok && (pend_q != 2'b00);
    // On a tie the core that did not win last time gets the slot.
    assign gnt_core  = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];

    assign dec[0]    = c0_decode && trace_en;
    assign dec[1]    = c1_decode && trace_en;
    assign new_ev[0] = '{core: 1'b0, pc: c0_pc, ir: c0_ir, irq: c0_irq_detect, ts: ts_cnt_q};
    assign new_ev[1] = '{core: 1'b1, pc: c1_pc, ir: c1_ir, irq: c1_irq_detect, ts: ts_cnt_q};

    always_comb begin
        pend_d  = pend_q;
        granted = 2'b00;
        drop    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            slot_d[i]  = slot_q[i];
            granted[i] = gnt_valid && (gnt_core == 1'(i));
            drop[i]    = dec[i] && pend_q[i] && !granted[i];
            // A slot drained this cycle can accept the new event without loss.
            if (dec[i] && (!pend_q[i] || granted[i])) begin
                slot_d[i] = new_ev[i];
                pend_d[i] = 1'b1;
            end else if (granted[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        case ({gnt_valid, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ts_cnt_q     <= '0;
            pend_q       <= 2'b00;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop0_q      <= '0;
            drop1_q      <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < 2; i++) slot_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ts_cnt_q  <= ts_cnt_q + TS_W'(1);
            pend_q    <= pend_d;
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            level_q   <= level_d;
            if (gnt_valid) begin
                mem_q[wr_ptr_q] <= slot_q[gnt_core];
                wr_ptr_q        <= wr_ptr_q + AW'(1);
                last_grant_q    <= gnt_core;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            // Clearing takes precedence over a drop landing on the same edge.
            if (clear_stats) begin
                drop0_q <= '0;
                drop1_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (drop[0] && drop0_q != 16'hFFFF) drop0_q <= drop0_q + 16'd1;
                if (drop[1] && drop1_q != 16'hFFFF) drop1_q <= drop1_q + 16'd1;
                if (drop != 2'b00) ovf_q <= 1'b1;
            end
        end
    end

    assign trc_core   = mem_q[rd_ptr_q].core;
    assign trc_pc     = mem_q[rd_ptr_q].pc;
    assign trc_ir     = mem_q[rd_ptr_q].ir;
    assign trc_irq    = mem_q[rd_ptr_q].irq;
    assign trc_ts     = mem_q[rd_ptr_q].ts;
    assign fifo_level = level_q;
    assign drop_cnt0  = drop0_q;
    assign drop_cnt1  = drop1_q;
    assign overflow   = ovf_q;
endmodule
